// File: rtl/apb_pkg.sv
// Shared types for the APB master/arbiter: FSM state encoding and the captured command record.
package apb_pkg;

    localparam int APB_ADDR_W = 4;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERR
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    function automatic logic is_aligned(input logic [APB_ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search begins one past the pointer and wraps.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] w_cand;
    logic          w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 1; i <= N; i++) begin
            w_cand = IW'((int'(i_ptr) + i) % N);
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// Multi-requester APB master: round-robin picks one command port, runs SETUP/ACCESS with a
// bounded PREADY wait, and returns read data / error to the winner as a one-cycle pulse.
module apb_master_arb
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_W,
    parameter int DATA_WIDTH = APB_DATA_W,
    parameter int NUM_REQ    = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PREADY
);

    localparam int IW     = $clog2(NUM_REQ);
    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

    apb_state_e            r_state;
    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         r_idx;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [WAIT_W-1:0]     r_wait;

    logic [NUM_REQ-1:0]    w_gnt;
    logic [NUM_REQ-1:0]    w_ready;
    logic [IW-1:0]         w_idx;
    apb_cmd_t              w_cmd;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    // Ready is held low while reset is asserted so every output reads 0 during reset.
    assign w_ready = (r_state == IDLE && PRESETn) ? w_gnt : '0;

    always_comb begin
        w_cmd.write = req_write[w_idx];
        w_cmd.addr  = req_addr[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        w_cmd.wdata = req_wdata[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= IDLE;
            r_ptr       <= IW'(NUM_REQ - 1);
            r_idx       <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= '0;
            r_wait      <= '0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (|w_ready) begin
                        r_ptr <= w_idx;
                        r_idx <= w_idx;
                        if (is_aligned(w_cmd.addr)) begin
                            r_state  <= SETUP;
                            r_psel   <= 1'b1;
                            r_pwrite <= w_cmd.write;
                            r_paddr  <= w_cmd.addr;
                            r_pwdata <= w_cmd.wdata;
                            r_wait   <= '0;
                        end else begin
                            r_state <= ERR;
                        end
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        r_state            <= IDLE;
                        r_psel             <= 1'b0;
                        r_penable          <= 1'b0;
                        r_rdata            <= r_pwrite ? '0 : PRDATA;
                        r_err              <= 1'b0;
                        r_rsp_valid[r_idx] <= 1'b1;
                    end else if ((TIMEOUT != 0) && (r_wait == WAIT_LAST)) begin
                        r_state            <= IDLE;
                        r_psel             <= 1'b0;
                        r_penable          <= 1'b0;
                        r_rdata            <= '0;
                        r_err              <= 1'b1;
                        r_rsp_valid[r_idx] <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ERR: begin
                    r_state            <= IDLE;
                    r_rdata            <= '0;
                    r_err              <= 1'b1;
                    r_rsp_valid[r_idx] <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: a small APB register slave with programmable wait states,
// a table of single transfers, and hand sequences for timing, reset-abort and round-robin.
module tb_apb_master_arb;

    logic        PCLK;
    logic        PRESETn;
    logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic [31:0] rsp_rdata, PWDATA, PRDATA;
    logic        rsp_err, PSEL, PENABLE, PWRITE, PREADY;
    logic [3:0]  PADDR;

    int n_cmp = 0;
    int n_bad = 0;

    apb_master_arb #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REQ(2), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    // Slave: four word registers; PREADY held low for wait_cfg ACCESS cycles.
    logic [31:0] mem [4];
    int wait_cfg = 0;
    int acc_cnt  = 0;
    assign PREADY = (acc_cnt >= wait_cfg);
    assign PRDATA = mem[PADDR[3:2]];
    always @(posedge PCLK) begin
        acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[3:2]] <= PWDATA;
    end

    // Bus monitor: running totals of select cycles, access cycles and address/data changes in ACCESS.
    int psel_tot = 0, acc_tot = 0, unst_tot = 0;
    logic [3:0]  s_addr;
    logic [31:0] s_wdata;
    always @(negedge PCLK) begin
        if (PSEL) psel_tot <= psel_tot + 1;
        if (PSEL && !PENABLE) begin
            s_addr  <= PADDR;
            s_wdata <= PWDATA;
        end
        if (PSEL && PENABLE) begin
            acc_tot <= acc_tot + 1;
            if (PADDR !== s_addr || PWDATA !== s_wdata) unst_tot <= unst_tot + 1;
        end
    end

    typedef struct {
        int          port;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        int          wait_n;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_psel;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int t, lat, p0, a0, u0;
        logic [1:0] onehot;
        onehot   = 2'b01 << v.port;
        p0       = psel_tot;
        a0       = acc_tot;
        u0       = unst_tot;
        wait_cfg = v.wait_n;
        @(negedge PCLK);
        req_valid[v.port]            = 1'b1;
        req_write[v.port]            = v.wr;
        req_addr[v.port*4 +: 4]      = v.addr;
        req_wdata[v.port*32 +: 32]   = v.wdata;
        #1;
        t = 0;
        while (req_ready !== onehot && t < 40) begin
            @(negedge PCLK);
            #1;
            t++;
        end
        chk($sformatf("v%0d_ready", k), req_ready, onehot);
        @(negedge PCLK);
        req_valid[v.port] = 1'b0;
        lat = 1;
        while (rsp_valid === 2'b00 && lat < 40) begin
            @(negedge PCLK);
            lat++;
        end
        chk($sformatf("v%0d_rsp_valid", k), rsp_valid, onehot);
        chk($sformatf("v%0d_rdata", k), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_err", k), rsp_err, v.exp_err);
        chk($sformatf("v%0d_latency", k), lat, v.exp_lat);
        chk($sformatf("v%0d_psel_after", k), {PSEL, PENABLE}, 2'b00);
        #1;
        chk($sformatf("v%0d_psel_cycles", k), psel_tot - p0, v.exp_psel);
        chk($sformatf("v%0d_access_cycles", k), acc_tot - a0, (v.exp_psel > 0) ? v.exp_psel - 1 : 0);
        chk($sformatf("v%0d_bus_stable", k), unst_tot - u0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ng, nr, cyc, t;
        int gnt_port [4];
        int gnt_cyc  [4];
        int rsp_port [4];
        int rsp_cyc  [4];
        logic [31:0] rsp_dat [4];

        //              port wr    addr   wdata          wait rdata          err  lat psel
        vecs[0] = '{0, 1'b1, 4'h4, 32'hDEADBEEF, 0,  32'h0,         1'b0, 3,  2};
        vecs[1] = '{0, 1'b0, 4'h4, 32'h0,        0,  32'hDEADBEEF,  1'b0, 3,  2};
        vecs[2] = '{1, 1'b1, 4'h8, 32'h12345678, 0,  32'h0,         1'b0, 3,  2};
        vecs[3] = '{1, 1'b0, 4'h8, 32'h0,        0,  32'h12345678,  1'b0, 3,  2};
        vecs[4] = '{0, 1'b1, 4'hC, 32'hA5A5A5A5, 3,  32'h0,         1'b0, 6,  5};
        vecs[5] = '{1, 1'b0, 4'hC, 32'h0,        3,  32'hA5A5A5A5,  1'b0, 6,  5};
        vecs[6] = '{1, 1'b0, 4'h6, 32'h0,        0,  32'h0,         1'b1, 2,  0};
        vecs[7] = '{0, 1'b1, 4'h1, 32'h77,       0,  32'h0,         1'b1, 2,  0};
        vecs[8] = '{0, 1'b0, 4'h0, 32'h0,        99, 32'h0,         1'b1, 18, 17};
        vecs[9] = '{1, 1'b0, 4'h4, 32'h0,        0,  32'hDEADBEEF,  1'b0, 3,  2};

        PCLK      = 1'b0;
        PRESETn   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(negedge PCLK);
        #1;
        chk("rst_psel", {PSEL, PENABLE, PWRITE}, 3'b000);
        chk("rst_paddr", PADDR, 4'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_data", {rsp_err, rsp_rdata}, 33'h0);
        chk("rst_req_ready", req_ready, 2'b00);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // Cycle-exact write: SETUP the cycle after accept, ACCESS the next, response after that.
        @(negedge PCLK);
        req_valid[0]    = 1'b1;
        req_write[0]    = 1'b1;
        req_addr[3:0]   = 4'h0;
        req_wdata[31:0] = 32'h11112222;
        #1;
        chk("seq_ready", req_ready, 2'b01);
        chk("seq_psel_at_accept", PSEL, 1'b0);
        @(negedge PCLK);
        req_valid[0] = 1'b0;
        chk("seq_setup_sel", {PSEL, PENABLE}, 2'b10);
        chk("seq_setup_addr", {PWRITE, PADDR}, 5'b1_0000);
        chk("seq_setup_wdata", PWDATA, 32'h11112222);
        chk("seq_setup_ready", req_ready, 2'b00);
        @(negedge PCLK);
        chk("seq_access_sel", {PSEL, PENABLE}, 2'b11);
        chk("seq_access_rsp", rsp_valid, 2'b00);
        @(negedge PCLK);
        chk("seq_rsp_valid", rsp_valid, 2'b01);
        chk("seq_rsp_err", rsp_err, 1'b0);
        chk("seq_idle_sel", {PSEL, PENABLE}, 2'b00);
        chk("seq_bus_held", {PWRITE, PWDATA}, {1'b1, 32'h11112222});
        @(negedge PCLK);
        chk("seq_rsp_pulse", rsp_valid, 2'b00);

        for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

        // Reset during a stalled ACCESS, with both ports requesting across the reset.
        wait_cfg = 99;
        @(negedge PCLK);
        req_valid[1]  = 1'b1;
        req_write[1]  = 1'b0;
        req_addr[7:4] = 4'h8;
        t = 0;
        while (!(PSEL && PENABLE) && t < 20) begin
            @(negedge PCLK);
            t++;
        end
        chk("mrst_in_access", {PSEL, PENABLE}, 2'b11);
        req_valid[0]  = 1'b1;
        req_write[0]  = 1'b0;
        req_addr[3:0] = 4'h4;
        #2;
        PRESETn = 1'b0;
        #1;
        chk("mrst_sel_drop", {PSEL, PENABLE}, 2'b00);
        chk("mrst_ready", req_ready, 2'b00);
        wait_cfg = 0;
        repeat (2) @(negedge PCLK);
        chk("mrst_no_rsp", rsp_valid, 2'b00);
        PRESETn = 1'b1;

        // Both ports held valid: grants must alternate starting at port 0, every 3 cycles.
        ng  = 0;
        nr  = 0;
        cyc = 0;
        while (nr < 4 && cyc < 60) begin
            #1;
            if (ng == 4) req_valid = 2'b00;
            if (rsp_valid != 2'b00) begin
                rsp_port[nr] = (rsp_valid == 2'b01) ? 0 : ((rsp_valid == 2'b10) ? 1 : 9);
                rsp_cyc[nr]  = cyc;
                rsp_dat[nr]  = rsp_rdata;
                nr++;
            end
            if (req_ready != 2'b00 && ng < 4) begin
                gnt_port[ng] = (req_ready == 2'b01) ? 0 : ((req_ready == 2'b10) ? 1 : 9);
                gnt_cyc[ng]  = cyc;
                ng++;
            end
            @(negedge PCLK);
            cyc++;
        end
        chk("alt_grants_seen", ng, 4);
        chk("alt_rsps_seen", nr, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ng) begin
                chk($sformatf("alt_gnt%0d_port", i), gnt_port[i], i % 2);
                chk($sformatf("alt_gnt%0d_cycle", i), gnt_cyc[i], 3 * i);
            end
            if (i < nr) begin
                chk($sformatf("alt_rsp%0d_port", i), rsp_port[i], i % 2);
                chk($sformatf("alt_rsp%0d_cycle", i), rsp_cyc[i], 3 * i + 3);
                chk($sformatf("alt_rsp%0d_data", i), rsp_dat[i], (i % 2 == 0) ? 32'hDEADBEEF : 32'h12345678);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
